// File: rtl/rotary_pulse_gen.sv
// Rotary encoder front end: synchronizes and debounces the two quadrature
// channels and the push switch, then decodes full detents into one-cycle
// direction strobes plus a one-cycle press strobe.
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | resting detent, AB = 11
// CW1   | clockwise, first quarter seen (AB = 01)
// CW2   | clockwise, second quarter seen (AB = 00)
// CW3   | clockwise, third quarter seen (AB = 10)
// CCW1  | counter-clockwise, first quarter seen (AB = 10)
// CCW2  | counter-clockwise, second quarter seen (AB = 00)
// CCW3  | counter-clockwise, third quarter seen (AB = 01)
// ERR   | illegal jump seen, wait for AB = 11 before rearming

module rotary_pulse_gen #(
    parameter int DEB_CYCLES = 1200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_a,
    input  logic key_b,
    input  logic key_ok,
    output logic L_pulse,
    output logic R_pulse,
    output logic ok_pulse
);

    localparam int CNT_W = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] CW1  = 3'd1;
    localparam logic [2:0] CW2  = 3'd2;
    localparam logic [2:0] CW3  = 3'd3;
    localparam logic [2:0] CCW1 = 3'd4;
    localparam logic [2:0] CCW2 = 3'd5;
    localparam logic [2:0] CCW3 = 3'd6;
    localparam logic [2:0] ERR  = 3'd7;

    // channel packing used throughout: [2] = A, [1] = B, [0] = OK
    logic [2:0]       raw;
    logic [2:0]       sync1_q;
    logic [2:0]       sync2_q;
    logic [2:0]       filt_q;
    logic [2:0]       filt_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic [1:0] ab;
    logic       r_pulse_q;
    logic       r_pulse_d;
    logic       l_pulse_q;
    logic       l_pulse_d;
    logic       ok_dly_q;
    logic       ok_pulse_q;

    assign raw = {key_a, key_b, key_ok};
    assign ab  = filt_q[2:1];

    // Two-flop synchronizers; reset to the idle-high level of every input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count consecutive mismatching cycles, accept the new level
    // once DEB_CYCLES mismatches in a row have been seen.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 3'b111;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            filt_q <= filt_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Detent decoder: one quarter step forward or back is legal, anything
    // else parks in ERR until the encoder is back at rest.
    always_comb begin
        state_d   = state_q;
        r_pulse_d = 1'b0;
        l_pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                case (ab)
                    2'b01:   state_d = CW1;
                    2'b10:   state_d = CCW1;
                    2'b00:   state_d = ERR;
                    default: state_d = IDLE;
                endcase
            end
            CW1: begin
                case (ab)
                    2'b00:   state_d = CW2;
                    2'b11:   state_d = IDLE;
                    2'b10:   state_d = ERR;
                    default: state_d = CW1;
                endcase
            end
            CW2: begin
                case (ab)
                    2'b10:   state_d = CW3;
                    2'b01:   state_d = CW1;
                    2'b11:   state_d = ERR;
                    default: state_d = CW2;
                endcase
            end
            CW3: begin
                case (ab)
                    2'b11: begin
                        state_d   = IDLE;
                        r_pulse_d = 1'b1;
                    end
                    2'b00:   state_d = CW2;
                    2'b01:   state_d = ERR;
                    default: state_d = CW3;
                endcase
            end
            CCW1: begin
                case (ab)
                    2'b00:   state_d = CCW2;
                    2'b11:   state_d = IDLE;
                    2'b01:   state_d = ERR;
                    default: state_d = CCW1;
                endcase
            end
            CCW2: begin
                case (ab)
                    2'b01:   state_d = CCW3;
                    2'b10:   state_d = CCW1;
                    2'b11:   state_d = ERR;
                    default: state_d = CCW2;
                endcase
            end
            CCW3: begin
                case (ab)
                    2'b11: begin
                        state_d   = IDLE;
                        l_pulse_d = 1'b1;
                    end
                    2'b00:   state_d = CCW2;
                    2'b10:   state_d = ERR;
                    default: state_d = CCW3;
                endcase
            end
            ERR: begin
                if (ab == 2'b11) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and registered direction strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            r_pulse_q <= 1'b0;
            l_pulse_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_pulse_q <= r_pulse_d;
            l_pulse_q <= l_pulse_d;
        end
    end

    // Press strobe: falling edge of the filtered switch, one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ok_dly_q   <= 1'b1;
            ok_pulse_q <= 1'b0;
        end else begin
            ok_dly_q   <= filt_q[0];
            ok_pulse_q <= ok_dly_q & ~filt_q[0];
        end
    end

    assign R_pulse  = r_pulse_q;
    assign L_pulse  = l_pulse_q;
    assign ok_pulse = ok_pulse_q;

endmodule

// File: tb/tb_rotary_pulse_gen.sv
// Bench for rotary_pulse_gen: a quadrature-position model predicts every
// output cycle by cycle; directed detent sequences add literal expectations.

module tb_rotary_pulse_gen;

    localparam int DEB = 4;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic key_a  = 1'b1;
    logic key_b  = 1'b1;
    logic key_ok = 1'b1;
    logic L_pulse;
    logic R_pulse;
    logic ok_pulse;

    rotary_pulse_gen #(.DEB_CYCLES(DEB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_a    (key_a),
        .key_b    (key_b),
        .key_ok   (key_ok),
        .L_pulse  (L_pulse),
        .R_pulse  (R_pulse),
        .ok_pulse (ok_pulse)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_r  = 0;
    int n_l  = 0;
    int n_ok = 0;

    // model state: raw sample history per channel (0 = A, 1 = B, 2 = OK)
    bit       m_hist [3][DEB+2];
    bit       m_filt [3];
    bit       m_ok_seen;
    bit [1:0] m_ab;
    int       m_disp;
    bit       m_err;
    bit       exp_r;
    bit       exp_l;
    bit       exp_ok;

    // position on the quadrature cycle, counting clockwise from rest
    function automatic int gpos(input bit [1:0] ab);
        case (ab)
            2'b11:   return 0;
            2'b01:   return 1;
            2'b00:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            for (int j = 0; j < DEB + 2; j++) m_hist[c][j] = 1'b1;
            m_filt[c] = 1'b1;
        end
        m_ok_seen = 1'b1;
        m_ab      = 2'b11;
        m_disp    = 0;
        m_err     = 1'b0;
        exp_r     = 1'b0;
        exp_l     = 1'b0;
        exp_ok    = 1'b0;
    endtask

    // Model: a level is accepted once it has been seen DEB samples in a row
    // (two cycles of synchronizer delay); detents are tracked as signed
    // quarter-turn displacement from rest, a full turn of +-4 yields a strobe.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                bit [1:0] ab;
                int       d;
                bit       raw [3];
                bit       flip;
                ab    = {m_filt[0], m_filt[1]};
                exp_r = 1'b0;
                exp_l = 1'b0;
                if (m_err) begin
                    if (ab == 2'b11) begin
                        m_err  = 1'b0;
                        m_disp = 0;
                    end
                end else if (ab != m_ab) begin
                    d = (gpos(ab) - gpos(m_ab) + 4) % 4;
                    if (d == 2) begin
                        m_err = 1'b1;
                    end else begin
                        m_disp += (d == 1) ? 1 : -1;
                        if (m_disp == 4) begin
                            exp_r  = 1'b1;
                            m_disp = 0;
                        end else if (m_disp == -4) begin
                            exp_l  = 1'b1;
                            m_disp = 0;
                        end
                    end
                end
                m_ab = ab;
                exp_ok    = m_ok_seen & ~m_filt[2];
                m_ok_seen = m_filt[2];
                raw[0] = key_a;
                raw[1] = key_b;
                raw[2] = key_ok;
                for (int c = 0; c < 3; c++) begin
                    flip = 1'b1;
                    for (int j = 1; j <= DEB; j++) begin
                        if (m_hist[c][j] == m_filt[c]) flip = 1'b0;
                    end
                    if (flip) m_filt[c] = ~m_filt[c];
                    for (int j = DEB + 1; j > 0; j--) m_hist[c][j] = m_hist[c][j-1];
                    m_hist[c][0] = raw[c];
                end
            end
        end
    end

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (R_pulse === 1'b1) n_r++;
            if (L_pulse === 1'b1) n_l++;
            if (ok_pulse === 1'b1) n_ok++;
            checks++;
            if ({L_pulse, R_pulse, ok_pulse} !== {exp_l, exp_r, exp_ok}) begin
                errors++;
                $display("FAIL pulses @%0t: got L/R/ok=%b%b%b want %b%b%b", $time,
                         L_pulse, R_pulse, ok_pulse, exp_l, exp_r, exp_ok);
            end
            checks++;
            if (dut.filt_q !== {m_filt[0], m_filt[1], m_filt[2]}) begin
                errors++;
                $display("FAIL filtered @%0t: got %b want %b", $time, dut.filt_q,
                         {m_filt[0], m_filt[1], m_filt[2]});
            end
            checks++;
            if ((dut.state_q == 3'd0) != (!m_err && m_disp == 0)) begin
                errors++;
                $display("FAIL at_rest @%0t: got state %0d want rest=%0d", $time,
                         dut.state_q, (!m_err && m_disp == 0));
            end
            checks++;
            if (L_pulse === 1'b1 && R_pulse === 1'b1) begin
                errors++;
                $display("FAIL exclusive @%0t: got L=1 R=1 want not both", $time);
            end
        end
    end

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Inputs change 2 time units after a rising edge; the following edge is
    // the first one that samples the new level.
    task automatic step(input bit [1:0] ab, input int n);
        {key_a, key_b} = ab;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic cw_seq();
        step(2'b01, 10);
        step(2'b00, 10);
        step(2'b10, 10);
        step(2'b11, 10);
    endtask

    int br, bl, bok, lat;

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_int("reset_outputs", {L_pulse, R_pulse, ok_pulse}, 0);
        check_int("reset_filtered", dut.filt_q, 3'b111);
        check_int("reset_state", dut.state_q, 0);
        #1 rst_n = 1'b1;

        // at rest: nothing fires
        br = n_r; bl = n_l; bok = n_ok;
        repeat (30) @(posedge clk);
        #2;
        check_int("idle_pulses", (n_r - br) + (n_l - bl) + (n_ok - bok), 0);

        // clockwise detent with strobe latency measured from the final edge
        br = n_r; bl = n_l;
        step(2'b01, 10);
        step(2'b00, 10);
        step(2'b10, 10);
        {key_a, key_b} = 2'b11;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (R_pulse === 1'b1 && lat < 0) lat = i;
        end
        #1;
        check_int("cw_latency_edges", lat, 7);
        check_int("cw_r_count", n_r - br, 1);
        check_int("cw_l_count", n_l - bl, 0);

        // counter-clockwise detent
        br = n_r; bl = n_l;
        step(2'b10, 10);
        step(2'b00, 10);
        step(2'b01, 10);
        step(2'b11, 10);
        check_int("ccw_l_count", n_l - bl, 1);
        check_int("ccw_r_count", n_r - br, 0);

        // reversal mid-detent
        br = n_r; bl = n_l;
        step(2'b01, 10);
        step(2'b00, 10);
        step(2'b01, 10);
        step(2'b11, 10);
        check_int("rev_pulses", (n_r - br) + (n_l - bl), 0);
        check_int("rev_state_idle", dut.state_q, 0);

        // short glitches on A and on the switch
        br = n_r; bl = n_l; bok = n_ok;
        key_a = 1'b0;
        repeat (3) @(posedge clk);
        #2 key_a = 1'b1;
        repeat (15) @(posedge clk);
        #2 key_ok = 1'b0;
        repeat (3) @(posedge clk);
        #2 key_ok = 1'b1;
        repeat (15) @(posedge clk);
        #2;
        check_int("glitch_filtered", dut.filt_q, 3'b111);
        check_int("glitch_pulses", (n_r - br) + (n_l - bl) + (n_ok - bok), 0);

        // two-bit jump to ERR, recovery, then a clean detent
        br = n_r; bl = n_l;
        step(2'b00, 10);
        check_int("err_state", dut.state_q, 7);
        step(2'b11, 10);
        check_int("err_pulses", (n_r - br) + (n_l - bl), 0);
        cw_seq();
        check_int("after_err_r", n_r - br, 1);
        check_int("after_err_l", n_l - bl, 0);

        // switch held low across a clockwise detent
        br = n_r; bl = n_l; bok = n_ok;
        key_ok = 1'b0;
        cw_seq();
        step(2'b11, 10);
        key_ok = 1'b1;
        step(2'b11, 10);
        check_int("hold_ok_count", n_ok - bok, 1);
        check_int("hold_r_count", n_r - br, 1);
        check_int("hold_l_count", n_l - bl, 0);

        // reset in the middle of a detent
        br = n_r; bl = n_l; bok = n_ok;
        step(2'b01, 10);
        step(2'b00, 10);
        rst_n = 1'b0;
        #1;
        check_int("midrst_outputs", {L_pulse, R_pulse, ok_pulse}, 0);
        check_int("midrst_state", dut.state_q, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        step(2'b00, 15);
        step(2'b10, 10);
        step(2'b11, 15);
        check_int("midrst_pulses", (n_r - br) + (n_l - bl) + (n_ok - bok), 0);
        check_int("midrst_final_state", dut.state_q, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rotary_pulse_gen.md
ROTARY_PULSE_GEN -- requirements
Module: rotary_pulse_gen

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 1200 (100 us at 12 MHz), minimum 2; meaning: consecutive stable cycles required to accept a new level on an input.
REQ-002 SHALL have port clk, input, 1, system clock (12 MHz).
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port key_a, input, 1, encoder channel A, asynchronous, idle high.
REQ-005 SHALL have port key_b, input, 1, encoder channel B, asynchronous, idle high.
REQ-006 SHALL have port key_ok, input, 1, encoder push switch, asynchronous, active-low.
REQ-007 SHALL have port L_pulse, output, 1, one-cycle strobe per completed counter-clockwise detent.
REQ-008 SHALL have port R_pulse, output, 1, one-cycle strobe per completed clockwise detent.
REQ-009 SHALL have port ok_pulse, output, 1, one-cycle strobe per debounced press of key_ok.

Function
REQ-010 SHALL pass each of key_a, key_b, key_ok through a 2-flop synchronizer, with both flops reset to 1.
REQ-011 SHALL give each synchronized input its own debouncer: a counter that clears whenever the synchronized value equals the filtered value, and increments otherwise.
REQ-012 SHALL copy the synchronized value into the filtered value and clear the counter when the counter reaches DEB_CYCLES-1 while the mismatch persists.
REQ-013 SHALL treat any glitch shorter than DEB_CYCLES cycles as having no effect on the filtered value.
REQ-014 SHALL size each debounce counter to hold DEB_CYCLES-1 without overflow.
REQ-015 SHALL implement a detent FSM on filtered {A,B} with states IDLE, CW1, CW2, CW3, CCW1, CCW2, CCW3, ERR.
REQ-016 In IDLE (AB=11), the FSM SHALL go to CW1 on AB=01, to CCW1 on AB=10, to ERR on AB=00, and otherwise stay.
REQ-017 The clockwise path SHALL be CW1(01) -> CW2 on 00 -> CW3 on 10 -> IDLE on 11 with R_pulse.
REQ-018 The counter-clockwise path SHALL be CCW1(10) -> CCW2 on 00 -> CCW3 on 01 -> IDLE on 11 with L_pulse.
REQ-019 The FSM SHALL treat a one-step backtrack as legal: CW2/CCW2 step back to CW1/CCW1, CW3/CCW3 step back to CW2/CCW2, and CW1/CCW1 on 11 return to IDLE with no pulse.
REQ-020 From any non-IDLE state, the FSM SHALL go to ERR on any {A,B} change that is not a legal forward or backward step, including a two-bit change in one cycle.
REQ-021 In ERR, the FSM SHALL emit no pulse and SHALL return to IDLE only when AB=11.
REQ-022 L_pulse and R_pulse SHALL be registered and high for exactly one clk cycle, and SHALL never be high together.
REQ-023 R_pulse SHALL rise on the clock edge after the filtered {A,B} becomes 11 from CW3; L_pulse SHALL behave the same from CCW3.
REQ-024 ok_pulse SHALL be registered, high for one cycle on the clock edge after a filtered key_ok 1->0 transition, with no pulse on release.
REQ-025 Holding key_ok low SHALL produce exactly one ok_pulse.
REQ-026 ok_pulse SHALL be independent of the detent FSM and may coincide with L_pulse or R_pulse.
REQ-027 A raw input edge that is held stable SHALL reach its filtered value DEB_CYCLES+2 cycles after first being sampled; the resulting strobe SHALL follow one cycle later.
REQ-028 The design SHALL be fully synchronous to clk except for rst_n, with no combinational path from inputs to outputs.

Reset
REQ-029 On rst_n low, the block SHALL asynchronously set all synchronizer flops and filtered values to 1, clear all debounce counters, set the FSM to IDLE, and drive L_pulse, R_pulse and ok_pulse to 0.
REQ-030 Reset asserted mid-detent SHALL abort the detent; after release, the FSM SHALL start in IDLE and no pulse SHALL be emitted for the aborted sequence.
REQ-031 After reset release with inputs held at 11/1, outputs SHALL stay 0 indefinitely.

Verification (DEB_CYCLES=4 in simulation)
REQ-032 The bench SHALL drive AB 11->01->00->10->11, each step held 10 cycles, and check exactly one R_pulse, no L_pulse, with the pulse 7 cycles after the final edge is first sampled.
REQ-033 The bench SHALL drive AB 11->10->00->01->11, each step held 10 cycles, and check exactly one L_pulse, no R_pulse.
REQ-034 The bench SHALL drive AB 11->01->00->01->11 (reversal) and check that no pulse is produced and the FSM ends in IDLE.
REQ-035 The bench SHALL drive a 3-cycle low glitch on key_a, then a 3-cycle low glitch on key_ok, and check that the filtered values are unchanged and no pulses occur.
REQ-036 The bench SHALL drive AB 11->00 in one step, then 00->11, then a full clockwise sequence, and check no pulse through ERR followed by exactly one R_pulse.
REQ-037 The bench SHALL hold key_ok low for 50 cycles while running a clockwise detent, and check one ok_pulse and one R_pulse; it SHALL then assert rst_n mid-sequence (at AB=00) and check all outputs 0 and no pulse after release.
